instr_fetch_ctrl: RTL
=====================

// Module: instr_fetch_ctrl
// PURPOSE
//  Sequences the instruction ROM: owns the program counter, presents it as the ROM read address,
//  registers the returned word into a one-entry output slot with a valid/ready handshake to decode.
//  Handles start, branch/jump redirect, backpressure, halt-word detection and out-of-range faults.
//  Sits between the instruction ROM (combinational read) and the decode stage of the cpu.
// PARAMETERS
//  WIDTH                32            instruction and PC width in bits
//  INSTRACTION_NUMBERS  1             ROM depth in words; valid PCs are 0..INSTRACTION_NUMBERS-1
//  RESET_PC             0             PC loaded at reset and on every (re)start
//  HALT_WORD            32'hFFFFFFFF  fetched word that stops sequencing
//  CNT_W                16            width of the delivered-instruction counter
// PORTS
//  clk            in   1      clock, all state updates on rising edge
//  rst            in   1      asynchronous, active-low reset
//  start          in   1      1-cycle pulse: leave IDLE/HALT/FAULT, begin fetching at RESET_PC
//  imem_addr      out  WIDTH  ROM read address (= current PC), drives the ROM curr_command input
//  imem_data      in   WIDTH  ROM read data, valid in the same cycle as imem_addr
//  redirect_valid in   1      branch/jump taken this cycle
//  redirect_pc    in   WIDTH  target PC, sampled when redirect_valid=1
//  instr_out      out  WIDTH  registered instruction to decode
//  instr_pc       out  WIDTH  PC of instr_out
//  instr_valid    out  1      instr_out holds an undelivered instruction
//  instr_ready    in   1      decode accepts; transfer when instr_valid & instr_ready
//  halted         out  1      HALT_WORD fetched, sequencing stopped
//  fault          out  1      PC left ROM range, sequencing stopped
//  fetch_count    out  CNT_W  number of completed transfers since last start, saturating
// BEHAVIOUR
//  - Reset (rst=0, async): pc=RESET_PC, state=IDLE, instr_out=0, instr_pc=0, instr_valid=0,
//    halted=0, fault=0, fetch_count=0. imem_addr=pc (combinational from pc register) at all times.
//  - States: IDLE, RUN, HALT, FAULT. IDLE/HALT/FAULT --start--> RUN with pc=RESET_PC,
//    instr_valid=0, halted=0, fault=0, fetch_count=0. start in RUN is ignored.
//  - Slot free = !instr_valid | instr_ready. Fetch happens in RUN only when slot free.
//  - Normal fetch (RUN, slot free, no redirect, pc<INSTRACTION_NUMBERS, imem_data!=HALT_WORD):
//    instr_out<=imem_data, instr_pc<=pc, instr_valid<=1, pc<=pc+1 (mod 2^WIDTH).
//    Latency: word at address A appears on instr_out one cycle after imem_addr=A; throughput 1/cycle.
//  - Backpressure: instr_valid & !instr_ready -> instr_out, instr_pc, pc all hold.
//  - Transfer (instr_valid & instr_ready) increments fetch_count, saturating at 2^CNT_W-1;
//    if no new fetch that cycle, instr_valid<=0.
//  - Redirect (RUN only, highest priority): pc<=redirect_pc, instr_valid<=0, no fetch this cycle
//    (held/in-flight word squashed). If instr_ready was also 1, that transfer still counts.
//    First word from redirect_pc appears 2 cycles after redirect_valid. Ignored outside RUN.
//  - Out of range (RUN, slot free, pc>=INSTRACTION_NUMBERS, no redirect): -> FAULT, fault<=1,
//    instr_valid<=0, pc holds (faulting PC visible on imem_addr).
//  - Halt (RUN, slot free, in-range, imem_data==HALT_WORD, no redirect): word not delivered;
//    -> HALT, halted<=1, instr_valid<=0, pc holds at halt address.
//  - Priority within RUN, slot free: redirect > out-of-range > halt > normal fetch.
//  - rst mid-operation: immediate return to reset values regardless of state; no pending output.
// STRUCTURE
//  - Shared package cpu_fetch_pkg: state enum {IDLE,RUN,HALT,FAULT}, HALT_WORD default constant.
//  - Single module; the output slot (instr_out/instr_pc/instr_valid + transfer logic) is the one
//    natural sub-module, fetch_out_slot, if reused by later pipeline stages.
// TESTING
//  - Reset then start, ROM={A0,A1,A2,FFFFFFFF}, ready=1 -> instr_out A0,A1,A2 on 3 consecutive
//    cycles (instr_pc 0,1,2), then halted=1, instr_valid=0, fetch_count=3, imem_addr=3.
//  - ready=0 for 4 cycles with A1 valid -> instr_out/instr_pc=A1/1 held, imem_addr=2 held;
//    ready=1 -> A2 next cycle, no word lost or duplicated.
//  - redirect_valid=1, redirect_pc=0 while A2 valid and ready=0 -> A2 squashed, instr_valid=0
//    next cycle, A0 with instr_pc=0 the cycle after; fetch_count unchanged.
//  - INSTRACTION_NUMBERS=2, no halt word -> words 0,1 delivered, then fault=1, imem_addr=2,
//    instr_valid=0; start -> fault=0, fetch resumes at RESET_PC, fetch_count=0.
//  - rst asserted mid-RUN with valid output -> all outputs to reset values asynchronously;
//    redirect and start both pulsed in IDLE -> only start acts, fetch begins at RESET_PC.
//  - CNT_W=2, 5 transfers -> fetch_count saturates at 3.

Source files
------------

// File: rtl/cpu_fetch_pkg.sv
// Shared definitions for the instruction fetch path.
//   fetch_state_e     : sequencer state (IDLE, RUN, HALT, FAULT)
//   HALT_WORD_DEFAULT : instruction word that stops sequencing when fetched
package cpu_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/fetch_out_slot.sv
// One-entry output slot with a valid/ready handshake towards decode.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   load_i          capture data_i/pc_i and mark the slot valid
//   flush_i         drop the held word (ignored when load_i is set)
//   ready_i         consumer accepts the held word this cycle
//   data_i, pc_i    word and its PC to capture
//   data_o, pc_o    held word and its PC
//   valid_o         slot holds an undelivered word
//   xfer_o          a transfer completes this cycle (valid_o & ready_i)
module fetch_out_slot #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             flush_i,
  input  logic             ready_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [WIDTH-1:0] pc_i,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] pc_o,
  output logic             valid_o,
  output logic             xfer_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] pc_q;
  logic             valid_q;

  assign xfer_o  = valid_q & ready_i;
  assign data_o  = data_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      pc_q    <= pc_i;
      valid_q <= 1'b1;
    end else if (flush_i || xfer_o) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, drives it as the ROM address,
// registers the returned word into a one-entry slot for decode, and stops on
// a halt word or when the PC leaves the ROM range.
// Ports:
//   clk, rst                clock, asynchronous active-low reset
//   start                   leave IDLE/HALT/FAULT and fetch from RESET_PC
//   imem_addr / imem_data   combinational ROM read port (addr = PC)
//   redirect_valid/_pc      branch/jump target, acted on in RUN only
//   instr_out/_pc/_valid    registered instruction to decode
//   instr_ready             decode accepts the held instruction
//   halted, fault           sequencing stopped by halt word / out-of-range PC
//   fetch_count             saturating count of transfers since last start
module instr_fetch_ctrl
  import cpu_fetch_pkg::*;
#(
  parameter int unsigned      WIDTH               = 32,
  parameter int unsigned      INSTRACTION_NUMBERS = 1,
  parameter logic [WIDTH-1:0] RESET_PC            = '0,
  parameter logic [WIDTH-1:0] HALT_WORD           = WIDTH'(HALT_WORD_DEFAULT),
  parameter int unsigned      CNT_W               = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_data,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic [WIDTH-1:0] instr_out,
  output logic [WIDTH-1:0] instr_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] fetch_count
);

  // One extra bit so a depth of 2**WIDTH is still representable.
  localparam logic [WIDTH:0] DEPTH = (WIDTH+1)'(INSTRACTION_NUMBERS);

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic in_run, restart, redirect, slot_free, in_range, is_halt;
  logic load, flush, xfer;

  always_comb begin
    in_run    = (state_q == RUN);
    restart   = start && !in_run;
    redirect  = in_run && redirect_valid;
    slot_free = !instr_valid || instr_ready;
    in_range  = {1'b0, pc_q} < DEPTH;
    is_halt   = (imem_data == HALT_WORD);
    load      = in_run && !redirect && slot_free && in_range && !is_halt;
    // In RUN with a free slot and no load, we are entering HALT or FAULT.
    flush     = restart || (in_run && (redirect || (slot_free && !load)));
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      RUN: begin
        if (redirect) begin
          pc_d = redirect_pc;
        end else if (slot_free) begin
          if (!in_range)    state_d = FAULT;
          else if (is_halt) state_d = HALT;
          else              pc_d    = pc_q + WIDTH'(1);
        end
      end
      default: begin
        if (start) begin
          state_d = RUN;
          pc_d    = RESET_PC;
        end
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (restart)                  cnt_d = '0;
    else if (xfer && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  fetch_out_slot #(
    .WIDTH (WIDTH)
  ) u_slot (
    .clk     (clk),
    .rst_n   (rst),
    .load_i  (load),
    .flush_i (flush),
    .ready_i (instr_ready),
    .data_i  (imem_data),
    .pc_i    (pc_q),
    .data_o  (instr_out),
    .pc_o    (instr_pc),
    .valid_o (instr_valid),
    .xfer_o  (xfer)
  );

  assign imem_addr   = pc_q;
  assign halted      = (state_q == HALT);
  assign fault       = (state_q == FAULT);
  assign fetch_count = cnt_q;

endmodule
